// File: rtl/switch_debounce_ctrl.sv
// Debounced 18-bit switch port with an Avalon-MM register slave (DATA/MASK/EDGE/CTRL)
// and a level interrupt raised from masked edge-status bits.
module switch_debounce_ctrl #(
  parameter int SAMPLE_DIV = 50000,
  parameter int STABLE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [17:0] in_port,
  output logic [17:0] sw_state,
  output logic        irq
);

  localparam int N  = 18;
  localparam int PW = 20;
  localparam logic [PW-1:0] DIV_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [3:0]    CNT_LAST = 4'(STABLE_CNT - 1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  logic [N-1:0]        sync_p0;
  logic [N-1:0]        sync_p1;
  logic [PW-1:0]       pre_cnt;
  logic                tick;
  logic [N-1:0][3:0]   stab_cnt;
  logic [N-1:0][3:0]   stab_cnt_next;
  logic [N-1:0]        sw_next;
  logic [N-1:0]        mask_reg;
  logic [N-1:0]        edge_status;
  logic [N-1:0]        edge_set;
  logic [N-1:0]        edge_clr;
  logic [N-1:0]        edge_next;
  logic [2:0]          ctrl_reg;
  logic                ctrl_enable;
  logic                ctrl_rise;
  logic                ctrl_fall;
  logic                wr_en;
  logic                rd_en;
  logic [31:0]         rd_mux;
  logic                unused_wdata;

  assign ctrl_enable  = ctrl_reg[0];
  assign ctrl_rise    = ctrl_reg[1];
  assign ctrl_fall    = ctrl_reg[2];
  assign wr_en        = chipselect & write;
  assign rd_en        = chipselect & read;
  assign unused_wdata = ^writedata[31:N];

  // Stage p0/p1: two-flop synchronizer on the raw switch inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= in_port;
      sync_p1 <= sync_p0;
    end
  end

  // Sample prescaler; parked at zero while disabled so ticks resume on a full period
  assign tick = ctrl_enable && (pre_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (!ctrl_enable || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // A single agreeing sample wipes the run, so only an unbroken streak flips the bit
  always_comb begin
    sw_next       = sw_state;
    stab_cnt_next = stab_cnt;
    if (tick) begin
      for (int i = 0; i < N; i++) begin
        if (sync_p1[i] != sw_state[i]) begin
          if (stab_cnt[i] == CNT_LAST) begin
            sw_next[i]       = ~sw_state[i];
            stab_cnt_next[i] = '0;
          end else begin
            stab_cnt_next[i] = stab_cnt[i] + 4'd1;
          end
        end else begin
          stab_cnt_next[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_state <= '0;
      stab_cnt <= '0;
    end else begin
      sw_state <= sw_next;
      stab_cnt <= stab_cnt_next;
    end
  end

  // New edges are OR-ed in after the clear so a coincident set is never lost
  assign edge_set  = ({N{ctrl_rise}} & sw_next & ~sw_state) |
                     ({N{ctrl_fall}} & ~sw_next & sw_state);
  assign edge_clr  = (wr_en && address == ADDR_EDGE) ? writedata[N-1:0] : '0;
  assign edge_next = (edge_status & ~edge_clr) | edge_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_status <= '0;
      mask_reg    <= '0;
      ctrl_reg    <= 3'b111;
    end else begin
      edge_status <= edge_next;
      if (wr_en && address == ADDR_MASK) begin
        mask_reg <= writedata[N-1:0];
      end
      if (wr_en && address == ADDR_CTRL) begin
        ctrl_reg <= writedata[2:0];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux = {{(32-N){1'b0}}, sw_state};
      ADDR_MASK: rd_mux = {{(32-N){1'b0}}, mask_reg};
      ADDR_EDGE: rd_mux = {{(32-N){1'b0}}, edge_status};
      ADDR_CTRL: rd_mux = {29'b0, ctrl_reg};
      default:   rd_mux = '0;
    endcase
  end

  // Read data and irq are registered from the pre-edge register contents
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (rd_en) begin
        readdata <= rd_mux;
      end
      irq <= |(edge_status & mask_reg);
    end
  end

endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// Randomized and directed bench for switch_debounce_ctrl against a sample-level reference model.
module tb_switch_debounce_ctrl;

  localparam int SAMPLE_DIV = 4;
  localparam int STABLE_CNT = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [17:0] in_port = '0;
  logic [17:0] sw_state;
  logic        irq;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [17:0] m_s1, m_s2, m_sw, m_edge, m_mask;
  logic [2:0]  m_ctrl;
  int          m_pc;
  int          m_cnt [18];
  logic        m_irq;
  logic [31:0] m_rd;

  switch_debounce_ctrl #(.SAMPLE_DIV(SAMPLE_DIV), .STABLE_CNT(STABLE_CNT)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .sw_state(sw_state), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_sw = '0; m_edge = '0; m_mask = '0;
    m_ctrl = 3'b111; m_pc = 0; m_irq = 1'b0; m_rd = '0;
    for (int i = 0; i < 18; i++) m_cnt[i] = 0;
  endtask

  // One clock of behaviour: a sample every SAMPLE_DIV clocks, STABLE_CNT disagreeing samples flip a bit
  task automatic model_step();
    logic [17:0] nsw, set, clr;
    bit sample;
    if (chipselect && read) begin
      case (address)
        2'd0: m_rd = {14'b0, m_sw};
        2'd1: m_rd = {14'b0, m_mask};
        2'd2: m_rd = {14'b0, m_edge};
        default: m_rd = {29'b0, m_ctrl};
      endcase
    end
    m_irq = |(m_edge & m_mask);
    sample = m_ctrl[0] && (m_pc == SAMPLE_DIV - 1);
    m_pc = m_ctrl[0] ? (m_pc + 1) % SAMPLE_DIV : 0;
    nsw = m_sw;
    if (sample) begin
      for (int i = 0; i < 18; i++) begin
        if (m_s2[i] != m_sw[i]) begin
          m_cnt[i] = m_cnt[i] + 1;
          if (m_cnt[i] == STABLE_CNT) begin
            nsw[i] = ~m_sw[i];
            m_cnt[i] = 0;
          end
        end else begin
          m_cnt[i] = 0;
        end
      end
    end
    set = (m_ctrl[1] ? (nsw & ~m_sw) : 18'h0) | (m_ctrl[2] ? (~nsw & m_sw) : 18'h0);
    clr = (chipselect && write && address == 2'd2) ? writedata[17:0] : 18'h0;
    m_edge = (m_edge & ~clr) | set;
    if (chipselect && write && address == 2'd1) m_mask = writedata[17:0];
    if (chipselect && write && address == 2'd3) m_ctrl = writedata[2:0];
    m_s2 = m_s1;
    m_s1 = in_port;
    m_sw = nsw;
  endtask

  function automatic bit will_flip(int b);
    return m_ctrl[0] && (m_pc == SAMPLE_DIV - 1) && (m_s2[b] != m_sw[b]) &&
           (m_cnt[b] == STABLE_CNT - 1);
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
  endtask

  task automatic do_read(input logic [1:0] a);
    chipselect = 1'b1; read = 1'b1; address = a;
    cycle();
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    cycle();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic test_reset();
    in_port = '0;
    reset_n = 1'b0;
    model_reset();
    cycle(); cycle();
    reset_n = 1'b1;
    tests++; if (sw_state !== 18'h0) begin fails++; $display("FAIL reset_sw: got %h expected 0", sw_state); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", irq); end
    tests++; if (readdata !== 32'h0) begin fails++; $display("FAIL reset_rd: got %h expected 0", readdata); end
    do_read(2'd3);
    tests++; if (readdata !== 32'h7) begin fails++; $display("FAIL reset_ctrl: got %h expected 7", readdata); end
    do_read(2'd1);
    tests++; if (readdata !== 32'h0) begin fails++; $display("FAIL reset_mask: got %h expected 0", readdata); end
    do_read(2'd2);
    tests++; if (readdata !== 32'h0) begin fails++; $display("FAIL reset_edge: got %h expected 0", readdata); end
  endtask

  task automatic test_rise();
    int n = 0;
    do_write(2'd1, 32'h1);
    in_port[0] = 1'b1;
    while (sw_state[0] !== 1'b1 && n < 40) begin
      cycle();
      n++;
      tests++; if (sw_state !== m_sw) begin fails++; $display("FAIL rise_track: got %h expected %h", sw_state, m_sw); end
    end
    tests++; if (sw_state[0] !== 1'b1) begin fails++; $display("FAIL rise_timeout: got %b expected 1", sw_state[0]); end
    tests++; if (n < 11 || n > 14) begin fails++; $display("FAIL rise_latency: got %0d expected 11..14", n); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL rise_irq_early: got %b expected 0", irq); end
    cycle();
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL rise_irq: got %b expected 1", irq); end
    do_read(2'd2);
    tests++; if (readdata !== 32'h1) begin fails++; $display("FAIL rise_edge: got %h expected 1", readdata); end
  endtask

  task automatic test_glitch();
    do_write(2'd2, 32'h3FFFF);
    do_write(2'd1, 32'h21);
    in_port[5] = 1'b1;
    repeat (8) cycle();
    in_port[5] = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      tests++; if (sw_state[5] !== 1'b0) begin fails++; $display("FAIL glitch_sw: got %b expected 0", sw_state[5]); end
    end
    do_read(2'd2);
    tests++; if (readdata !== 32'h0) begin fails++; $display("FAIL glitch_edge: got %h expected 0", readdata); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL glitch_irq: got %b expected 0", irq); end
  endtask

  task automatic test_w1c_race();
    bit hit = 0;
    in_port[0] = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (will_flip(0)) begin
        hit = 1;
        chipselect = 1'b1; write = 1'b1; address = 2'd2; writedata = 32'h1;
        cycle();
        chipselect = 1'b0; write = 1'b0;
      end else begin
        cycle();
      end
    end
    tests++; if (!hit || sw_state[0] !== 1'b0) begin fails++; $display("FAIL race_flip: got %b expected 0", sw_state[0]); end
    do_read(2'd2);
    tests++; if (readdata !== 32'h1) begin fails++; $display("FAIL race_set_wins: got %h expected 1", readdata); end
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL race_irq: got %b expected 1", irq); end
    do_write(2'd2, 32'h1);
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL clr_irq_hold: got %b expected 1", irq); end
    cycle();
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL clr_irq_drop: got %b expected 0", irq); end
    do_read(2'd2);
    tests++; if (readdata !== 32'h0) begin fails++; $display("FAIL clr_edge: got %h expected 0", readdata); end
  endtask

  task automatic test_fall_only();
    int n = 0;
    do_write(2'd3, 32'h5);
    in_port[17] = 1'b1;
    while (sw_state[17] !== 1'b1 && n < 40) begin cycle(); n++; end
    tests++; if (sw_state[17] !== 1'b1) begin fails++; $display("FAIL fall_rise_flip: got %b expected 1", sw_state[17]); end
    do_read(2'd2);
    tests++; if (readdata !== 32'h0) begin fails++; $display("FAIL fall_no_rise_edge: got %h expected 0", readdata); end
    in_port[17] = 1'b0;
    n = 0;
    while (sw_state[17] !== 1'b0 && n < 40) begin cycle(); n++; end
    do_read(2'd2);
    tests++; if (readdata !== 32'h20000) begin fails++; $display("FAIL fall_edge: got %h expected 20000", readdata); end
    do_write(2'd3, 32'h7);
    do_write(2'd2, 32'h3FFFF);
  endtask

  task automatic test_data_read();
    in_port = 18'h3FFFF;
    repeat (24) cycle();
    do_read(2'd0);
    tests++; if (readdata !== 32'h0003FFFF) begin fails++; $display("FAIL data_read: got %h expected 3ffff", readdata); end
    do_write(2'd0, 32'h0);
    cycle();
    tests++; if (readdata !== 32'h0003FFFF) begin fails++; $display("FAIL data_hold: got %h expected 3ffff", readdata); end
    do_read(2'd0);
    tests++; if (readdata !== 32'h0003FFFF) begin fails++; $display("FAIL data_ro: got %h expected 3ffff", readdata); end
  endtask

  task automatic test_random();
    int op;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 9) == 0) in_port[$urandom_range(0, 17)] ^= 1'b1;
      op = $urandom_range(0, 9);
      chipselect = (op >= 5);
      read = (op >= 5 && op <= 7);
      write = (op >= 8);
      address = 2'($urandom_range(0, 3));
      writedata = $urandom;
      if (write && address == 2'd3 && $urandom_range(0, 3) != 0) writedata[0] = 1'b1;
      cycle();
      chipselect = 1'b0; read = 1'b0; write = 1'b0;
      tests++; if (sw_state !== m_sw) begin fails++; $display("FAIL rnd_sw: got %h expected %h", sw_state, m_sw); end
      tests++; if (irq !== m_irq) begin fails++; $display("FAIL rnd_irq: got %b expected %b", irq, m_irq); end
      tests++; if (readdata !== m_rd) begin fails++; $display("FAIL rnd_rd: got %h expected %h", readdata, m_rd); end
    end
    do_write(2'd3, 32'h7);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    in_port = '0;
    repeat (24) cycle();
    in_port = 18'h155;
    repeat (6) cycle();
    reset_n = 1'b0;
    model_reset();
    cycle(); cycle();
    reset_n = 1'b1;
    tests++; if (sw_state !== 18'h0) begin fails++; $display("FAIL rmid_sw: got %h expected 0", sw_state); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL rmid_irq: got %b expected 0", irq); end
    tests++; if (readdata !== 32'h0) begin fails++; $display("FAIL rmid_rd: got %h expected 0", readdata); end
    while (sw_state !== 18'h155 && n < 40) begin
      cycle();
      n++;
      tests++; if (irq !== 1'b0) begin fails++; $display("FAIL rmid_spurious_irq: got %b expected 0", irq); end
    end
    tests++; if (n != 12) begin fails++; $display("FAIL rmid_latency: got %0d expected 12", n); end
    do_read(2'd3);
    tests++; if (readdata !== 32'h7) begin fails++; $display("FAIL rmid_ctrl: got %h expected 7", readdata); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_rise();
    test_glitch();
    test_w1c_race();
    test_fall_only();
    test_data_read();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/switch_debounce_ctrl.md
SWITCH_DEBOUNCE_CTRL -- requirements
Module: switch_debounce_ctrl

Interface
REQ-001 Parameter SAMPLE_DIV, default 50000, sample-tick period in clk cycles (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 Parameter STABLE_CNT, default 4, consecutive disagreeing sample ticks needed to flip a debounced bit; legal range 1..15.
REQ-003 clk  input  1  system clock.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 address  input  2  Avalon-MM slave word address.
REQ-006 chipselect  input  1  slave select.
REQ-007 read  input  1  read strobe; qualified by chipselect.
REQ-008 write  input  1  write strobe; qualified by chipselect.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  registered read data.
REQ-011 in_port  input  18  raw, asynchronous, bouncing switch inputs.
REQ-012 sw_state  output  18  debounced switch state for fabric use.
REQ-013 irq  output  1  level interrupt, active-high.

Function
REQ-014 in_port SHALL pass through a 2-flop synchronizer per bit before any other use.
REQ-015 A prescaler SHALL count 0..SAMPLE_DIV-1 and assert a one-cycle tick when it wraps from SAMPLE_DIV-1 to 0; it counts only while CTRL.enable=1 and holds at 0 otherwise.
REQ-016 Each bit SHALL have a 4-bit stability counter; on a tick, sync bit != sw_state bit -> counter+1; sync bit == sw_state bit -> counter cleared to 0.
REQ-017 When a tick would bring a counter to STABLE_CNT, that sw_state bit SHALL invert on that same clock edge and its counter SHALL clear to 0.
REQ-018 Counters SHALL NOT change between ticks; a single agreeing tick SHALL discard any accumulated count (glitch rejection).
REQ-019 Register map: 0 DATA (RO) = {14'b0, sw_state}; 1 MASK (RW) bits[17:0]; 2 EDGE (RO, write-1-to-clear) bits[17:0]; 3 CTRL (RW) bit0 enable, bit1 rise_en, bit2 fall_en; unused bits read 0.
REQ-020 EDGE bit SHALL set on the cycle its sw_state bit flips 0->1 if rise_en=1, or 1->0 if fall_en=1.
REQ-021 Simultaneous EDGE set and write-1-to-clear of the same bit: set SHALL win.
REQ-022 irq SHALL be registered: irq = |(EDGE & MASK), asserting one clk cycle after the EDGE/MASK update.
REQ-023 Read latency SHALL be 1: readdata updates on the edge after chipselect&read and holds until the next read; no waitrequest.
REQ-024 Writes take effect on the edge where chipselect&write; writes to address 0 SHALL be ignored.
REQ-025 Clearing CTRL.enable SHALL freeze sw_state and counters; EDGE, MASK and irq remain accessible and live.

Reset
REQ-026 On reset_n low, asynchronously: sync flops, sw_state, counters, prescaler, EDGE, MASK = 0; CTRL = 3'b111; readdata = 0; irq = 0.
REQ-027 Reset release SHALL not create an EDGE event; first possible flip occurs after STABLE_CNT ticks.
REQ-028 Reset asserted mid-debounce SHALL discard all partial counts.

Verification (SAMPLE_DIV=4, STABLE_CNT=3 for bench)
REQ-029 in_port[0] 0->1 held steady -> sw_state[0]=1 on the 3rd tick after synchronizer settles; EDGE[0]=1; irq=1 next cycle if MASK[0]=1.
REQ-030 in_port[5] pulses high for 2 ticks then low -> sw_state[5] stays 0, EDGE=0, irq=0.
REQ-031 Write 0x1 to EDGE on the same cycle bit0 sets -> EDGE[0] stays 1; a later write 0x1 -> EDGE[0]=0, irq drops next cycle.
REQ-032 CTRL=3'b101 (rise disabled), in_port[17] 0->1 then 1->0 -> EDGE[17] set only after the falling flip.
REQ-033 Read address 0 with in_port=18'h3FFFF stable -> readdata=32'h0003FFFF one cycle after read; write to address 0 leaves it unchanged.
REQ-034 Assert reset_n during a partial count, release -> all outputs 0, CTRL readback 0x7, no spurious irq.
